// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port CPU front end that routes each load/store to
// either an on-chip 256-entry RAM (address bits [63:8] all zero) or to an
// external request/acknowledge peripheral bus (every other address).
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN adds an I/O wait watchdog
// that completes a stuck I/O access with cpuErr=1 after TIMEOUT_CYCLES.
// Without the macro an I/O access waits for ioAck indefinitely.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        cpuReq,
  input  logic        cpuWrite,
  input  logic [63:0] cpuAddr,
  input  logic [63:0] cpuWData,
  output logic [63:0] cpuRData,
  output logic        cpuDone,
  output logic        cpuErr,
  output logic        busy,
  output logic [7:0]  ramAddr,
  output logic [63:0] ramWData,
  output logic        ramWrEn,
  output logic        ramRdEn,
  input  logic [63:0] ramRData,
  output logic        ioReq,
  output logic        ioWrite,
  output logic [63:0] ioAddr,
  output logic [63:0] ioWData,
  input  logic        ioAck,
  input  logic [63:0] ioRData
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RAM_ACC = 3'd1;
  localparam logic [2:0] ST_RAM_CAP = 3'd2;
  localparam logic [2:0] ST_IO_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // The wait limit must fit the 8-bit watchdog counter and be non-zero.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_access_ctrl: TIMEOUT_CYCLES must lie in 1..255");
  end

  logic [2:0]  state_r;
  logic [2:0]  next_state_s;
  logic        accept_s;
  logic        is_ram_s;
  logic        tmo_hit_s;
  logic        tmo_take_s;
  logic        write_r;
  logic [63:0] rdata_r;
  logic        done_r;
  logic        err_r;
  logic        busy_r;
  logic [7:0]  ram_addr_r;
  logic [63:0] ram_wdata_r;
  logic        ram_wr_en_r;
  logic        ram_rd_en_r;
  logic        io_req_r;
  logic        io_write_r;
  logic [63:0] io_addr_r;
  logic [63:0] io_wdata_r;

  // Requests are only taken in IDLE; anything arriving later is dropped.
  assign accept_s = (state_r == ST_IDLE) && cpuReq;
  assign is_ram_s = (cpuAddr[63:8] == 56'd0);

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt_r;

  // The current IO_WAIT cycle is the last one allowed when it completes the count.
  assign tmo_hit_s = ((tmo_cnt_r + 8'd1) == TMO_LIMIT);

  // Watchdog: cleared on IO_WAIT entry, counts IO_WAIT cycles without ack.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      tmo_cnt_r <= 8'd0;
    end else if (accept_s && !is_ram_s) begin
      tmo_cnt_r <= 8'd0;
    end else if ((state_r == ST_IO_WAIT) && !ioAck) begin
      tmo_cnt_r <= tmo_cnt_r + 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // A late ack on the limit cycle wins over the timeout.
  assign tmo_take_s = (state_r == ST_IO_WAIT) && !ioAck && tmo_hit_s;

  // Next-state decode of the transaction sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpuReq) begin
          next_state_s = is_ram_s ? ST_RAM_ACC : ST_IO_WAIT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RAM_ACC: next_state_s = write_r ? ST_DONE : ST_RAM_CAP;
      ST_RAM_CAP: next_state_s = ST_DONE;
      ST_IO_WAIT: begin
        if (ioAck || tmo_hit_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_IO_WAIT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State register plus strobes/flags registered from the next-state decode.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ST_IDLE;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      ram_wr_en_r <= 1'b0;
      ram_rd_en_r <= 1'b0;
      io_req_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      done_r      <= (next_state_s == ST_DONE);
      err_r       <= tmo_take_s;
      busy_r      <= (next_state_s != ST_IDLE);
      ram_wr_en_r <= accept_s && is_ram_s && cpuWrite;
      ram_rd_en_r <= accept_s && is_ram_s && !cpuWrite;
      io_req_r    <= (next_state_s == ST_IO_WAIT);
    end
  end

  // Request latches: captured once on acceptance and held for the whole access.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      write_r     <= 1'b0;
      ram_addr_r  <= 8'd0;
      ram_wdata_r <= 64'd0;
      io_write_r  <= 1'b0;
      io_addr_r   <= 64'd0;
      io_wdata_r  <= 64'd0;
    end else if (accept_s && is_ram_s) begin
      write_r     <= cpuWrite;
      ram_addr_r  <= cpuAddr[7:0];
      ram_wdata_r <= cpuWData;
    end else if (accept_s) begin
      write_r     <= cpuWrite;
      io_write_r  <= cpuWrite;
      io_addr_r   <= cpuAddr;
      io_wdata_r  <= cpuWData;
    end else begin
      write_r     <= write_r;
    end
  end

  // Load data register: written only by load captures or a load timeout.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rdata_r <= 64'd0;
    end else if (state_r == ST_RAM_CAP) begin
      rdata_r <= ramRData;
    end else if ((state_r == ST_IO_WAIT) && ioAck && !write_r) begin
      rdata_r <= ioRData;
    end else if (tmo_take_s && !write_r) begin
      rdata_r <= 64'd0;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign cpuRData = rdata_r;
  assign cpuDone  = done_r;
  assign cpuErr   = err_r;
  assign busy     = busy_r;
  assign ramAddr  = ram_addr_r;
  assign ramWData = ram_wdata_r;
  assign ramWrEn  = ram_wr_en_r;
  assign ramRdEn  = ram_rd_en_r;
  assign ioReq    = io_req_r;
  assign ioWrite  = io_write_r;
  assign ioAddr   = io_addr_r;
  assign ioWData  = io_wdata_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// transactions compared against a transaction-level reference (expected
// latency, strobe counts, load data from a reference memory image).
// Timeout scenarios run only when MEM_ACCESS_TIMEOUT_EN is defined.
module tb_mem_access_ctrl;

  localparam int TMO = 16;

  logic        clock;
  logic        resetN;
  logic        cpuReq;
  logic        cpuWrite;
  logic [63:0] cpuAddr;
  logic [63:0] cpuWData;
  logic [63:0] cpuRData;
  logic        cpuDone;
  logic        cpuErr;
  logic        busy;
  logic [7:0]  ramAddr;
  logic [63:0] ramWData;
  logic        ramWrEn;
  logic        ramRdEn;
  logic [63:0] ramRData;
  logic        ioReq;
  logic        ioWrite;
  logic [63:0] ioAddr;
  logic [63:0] ioWData;
  logic        ioAck;
  logic [63:0] ioRData;

  int errors = 0;
  int checks = 0;
  int txn_id = 0;

  logic [63:0] ref_mem [256];
  logic [63:0] ref_rdata;

  logic [63:0] ram_mem [256];
  bit          ram_written [256];

  mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .resetN(resetN),
    .cpuReq(cpuReq), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuDone(cpuDone), .cpuErr(cpuErr), .busy(busy),
    .ramAddr(ramAddr), .ramWData(ramWData), .ramWrEn(ramWrEn), .ramRdEn(ramRdEn),
    .ramRData(ramRData),
    .ioReq(ioReq), .ioWrite(ioWrite), .ioAddr(ioAddr), .ioWData(ioWData),
    .ioAck(ioAck), .ioRData(ioRData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Power-on content of a RAM word that was never written.
  function automatic logic [63:0] pat(input logic [7:0] a);
    return 64'h0123_4567_89AB_CDEF ^ {8{a}};
  endfunction

  // Synchronous RAM device: read data valid the cycle after ramRdEn.
  always @(posedge clock) begin
    if (ramWrEn) begin
      ram_mem[ramAddr]     <= ramWData;
      ram_written[ramAddr] <= 1'b1;
    end
    if (ramRdEn) begin
      ramRData <= ram_written[ramAddr] ? ram_mem[ramAddr] : pat(ramAddr);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (txn %0d): observed=%h expected=%h", tag, txn_id, obs, exp);
    end
  endtask

  // One CPU transaction; ack_dly = ioReq cycle in which ioAck is given (0 = never).
  task automatic run_txn(input logic wr, input logic [63:0] addr, input logic [63:0] wd,
                         input int ack_dly, input logic [63:0] io_val,
                         input bit dup, input bit exp_tmo);
    logic        is_ram;
    logic [63:0] got_rdata, exp_rdata, got_wdata;
    logic        got_err, io_bad;
    logic [7:0]  got_ram_a;
    int          lat, n_done, n_wr, n_rd, n_io, exp_lat, exp_io;
    bit          seen;
    txn_id++;
    is_ram = (addr[63:8] == 56'd0);
    lat = 0; n_done = 0; n_wr = 0; n_rd = 0; n_io = 0; seen = 1'b0;
    got_rdata = 64'd0; got_wdata = 64'd0; got_err = 1'b0; io_bad = 1'b0; got_ram_a = 8'd0;
    cpuReq = 1'b1; cpuWrite = wr; cpuAddr = addr; cpuWData = wd;
    for (int c = 1; c <= 60 && !seen; c++) begin
      step();
      cpuReq = 1'b0;
      ioAck  = 1'b0;
      if (dup && c == 1) begin
        cpuReq = 1'b1; cpuWrite = ~wr; cpuAddr = ~addr; cpuWData = ~wd;
      end
      if (ramWrEn) begin n_wr++; got_ram_a = ramAddr; got_wdata = ramWData; end
      if (ramRdEn) begin n_rd++; got_ram_a = ramAddr; end
      if (ioReq) begin
        n_io++;
        if (ioAddr !== addr || ioWrite !== wr || ioWData !== wd) io_bad = 1'b1;
        if (n_io == ack_dly) begin ioAck = 1'b1; ioRData = io_val; end
      end
      if (cpuDone) begin
        seen = 1'b1; lat = c; n_done++; got_rdata = cpuRData; got_err = cpuErr;
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      cpuReq = 1'b0;
      ioAck  = 1'b0;
      if (ramWrEn) n_wr++;
      if (ramRdEn) n_rd++;
      if (ioReq)   n_io++;
      if (cpuDone) n_done++;
    end
    exp_lat = is_ram ? (wr ? 2 : 3) : (exp_tmo ? TMO + 1 : ack_dly + 1);
    exp_io  = is_ram ? 0 : (exp_tmo ? TMO : ack_dly);
    if (!wr) exp_rdata = is_ram ? ref_mem[addr[7:0]] : (exp_tmo ? 64'd0 : io_val);
    else     exp_rdata = ref_rdata;
    chk("latency",       64'(lat),    64'(exp_lat));
    chk("done_count",    64'(n_done), 64'd1);
    chk("ram_wr_count",  64'(n_wr),   (is_ram && wr)  ? 64'd1 : 64'd0);
    chk("ram_rd_count",  64'(n_rd),   (is_ram && !wr) ? 64'd1 : 64'd0);
    chk("io_req_cycles", 64'(n_io),   64'(exp_io));
    chk("rdata_at_done", got_rdata,   exp_rdata);
    chk("err_at_done",   64'(got_err), exp_tmo ? 64'd1 : 64'd0);
    chk("busy_after",    64'(busy),   64'd0);
    if (is_ram)       chk("ram_addr",  64'(got_ram_a), {56'd0, addr[7:0]});
    if (is_ram && wr) chk("ram_wdata", got_wdata, wd);
    if (!is_ram)      chk("io_fields_stable", 64'(io_bad), 64'd0);
    ref_rdata = exp_rdata;
    if (is_ram && wr) ref_mem[addr[7:0]] = wd;
    chk("rdata_held", cpuRData, ref_rdata);
  endtask

  logic [63:0] r_addr, r_data;
  logic        r_wr;

  initial begin
    resetN = 1'b0; cpuReq = 1'b0; cpuWrite = 1'b0; cpuAddr = 64'd0; cpuWData = 64'd0;
    ioAck = 1'b0; ioRData = 64'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
    ref_rdata = 64'd0;
    repeat (3) step();
    // Reset state of every output.
    chk("rst_done",  64'(cpuDone), 64'd0);
    chk("rst_busy",  64'(busy),    64'd0);
    chk("rst_ioreq", 64'(ioReq),   64'd0);
    chk("rst_strobes", {62'd0, ramWrEn, ramRdEn}, 64'd0);
    chk("rst_rdata", cpuRData,     64'd0);
    chk("rst_err",   64'(cpuErr),  64'd0);
    chk("rst_addrs", {ioAddr[55:0], ramAddr}, 64'd0);
    resetN = 1'b1;

    // First request right after reset release, RAM store to 0xA5.
    run_txn(1'b1, 64'h0000_0000_0000_00A5, 64'h1122_3344_5566_7788, 0, 64'd0, 1'b0, 1'b0);
    // RAM store then load at the top RAM address.
    run_txn(1'b1, 64'h0000_0000_0000_00FF, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'd0, 1'b0, 1'b0);
    run_txn(1'b0, 64'h0000_0000_0000_00FF, 64'd0, 0, 64'd0, 1'b0, 1'b0);
    // Never-written word, and a load of the A5 store.
    run_txn(1'b0, 64'h0000_0000_0000_0000, 64'd0, 0, 64'd0, 1'b0, 1'b0);
    run_txn(1'b0, 64'h0000_0000_0000_00A5, 64'd0, 0, 64'd0, 1'b0, 1'b0);
    // First I/O address, ack in the 4th ioReq cycle.
    run_txn(1'b0, 64'h0000_0000_0000_0100, 64'd0, 4, 64'h55, 1'b0, 1'b0);
    // Duplicate requests while busy must be dropped.
    run_txn(1'b1, 64'h0000_0000_0000_0010, 64'hA0A0_B1B1_C2C2_D3D3, 0, 64'd0, 1'b1, 1'b0);
    run_txn(1'b0, 64'h0000_0000_0000_0010, 64'd0, 0, 64'd0, 1'b1, 1'b0);
    run_txn(1'b1, 64'h0000_1234_0000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 2, 64'hFFFF, 1'b1, 1'b0);

    // ioAck while idle is ignored.
    ioAck = 1'b1; ioRData = 64'h9999_8888_7777_6666;
    step(); step();
    chk("idle_ack_done",  64'(cpuDone), 64'd0);
    chk("idle_ack_rdata", cpuRData, ref_rdata);
    ioAck = 1'b0;
    step();

    // Reset during IO_WAIT.
    cpuReq = 1'b1; cpuWrite = 1'b0; cpuAddr = 64'h0000_0000_0000_0200;
    step();
    cpuReq = 1'b0;
    step(); step();
    chk("pre_rst_ioreq", 64'(ioReq), 64'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("async_rst", {61'd0, ioReq, busy, cpuDone}, 64'd0);
    ref_rdata = 64'd0;
    @(posedge clock); #1;
    resetN = 1'b1;
    run_txn(1'b0, 64'h0000_0000_0000_0300, 64'd0, 3, 64'h1357_9BDF_2468_ACE0, 1'b0, 1'b0);

    // Random mix of RAM and I/O traffic.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) r_addr = {56'd0, 8'($urandom)};
      else r_addr = {$urandom, $urandom} | 64'h0000_0001_0000_0000;
      r_wr   = 1'($urandom);
      r_data = {$urandom, $urandom};
      run_txn(r_wr, r_addr, r_data, $urandom_range(8, 1), {$urandom, $urandom},
              ($urandom_range(3, 0) == 0), 1'b0);
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    // Store with no ack times out after TMO IO_WAIT cycles.
    run_txn(1'b1, 64'h8000_0000_0000_0000, 64'h0123_0123_0123_0123, 0, 64'd0, 1'b0, 1'b1);
    // Late ack after the timeout is ignored.
    ioAck = 1'b1; ioRData = 64'hBAD0_BAD0_BAD0_BAD0;
    step();
    ioAck = 1'b0;
    step();
    chk("late_ack_done", {62'd0, cpuDone, busy}, 64'd0);
    chk("late_ack_rdata", cpuRData, ref_rdata);
    // Load timeout clears the returned data.
    run_txn(1'b0, 64'h8000_0000_0000_0008, 64'd0, 0, 64'd0, 1'b0, 1'b1);
    // Ack on the limit cycle completes normally.
    run_txn(1'b0, 64'h8000_0000_0000_0010, 64'd0, TMO, 64'h7777, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
